// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared constants and state encoding for the RAM stream reader
package ram_stream_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LAT = 2;
endpackage

// File: rtl/stream_fifo4.sv
// stream_fifo4: 4-entry synchronous FIFO holding {last, data} beats for the output stream
// Ports: clk, resetn (async, active-low), push/din write side, pop read side,
//        flush empties the FIFO, dout/valid expose the head, count is the occupancy.
module stream_fifo4 import ram_stream_pkg::*; #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [2:0]   count
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0] wp, rp;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + 2'd1 : wp;
      rp <= pop ? rp + 2'd1 : rp;
      count <= count + 3'(push) - 3'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
  // head is forced to zero while empty so the stream outputs read as cleared
  assign valid = count != '0;
  assign dout = valid ? mem[rp] : '0;
  push_when_full: assert property (@(posedge clk) disable iff (!resetn) !(push && count == 3'(FIFO_DEPTH)));
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks an address range on a RAM read port and streams the data out
// Ports: clk, resetn (async, active-low); start/base_addr/length request a transfer,
//        abort cancels it; busy/done report status; raddr/rdata drive the RAM read port
//        (one-cycle registered latency); m_data/m_valid/m_last/m_ready form the output stream.
module ram_stream_reader import ram_stream_pkg::*; #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] rdata
);
  state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] len_r, icnt;
  logic [$clog2(RD_LAT+1)-1:0] inflight;
  logic [2:0] fifo_count;
  logic [3:0] occ;
  logic [DATA_WIDTH:0] head;
  logic iss, cap, cap_keep, iss_last, cap_last, zdone;
  logic accept, kill, hs, iss_nxt, push;
  // iss: raddr holds a live read this cycle; cap: rdata holds that read's data this cycle
  assign inflight = 2'(iss) + 2'(cap);
  assign occ = 4'(fifo_count) + 4'(inflight);
  assign accept = state == ST_IDLE && start && inflight == '0;
  assign kill = state != ST_IDLE && abort;
  assign hs = m_valid && m_ready;
  // occupancy check uses pre-pop counts so every committed read always has a FIFO slot
  assign iss_nxt = accept ? length != '0
                 : state == ST_ISSUE && !kill && icnt != len_r && occ < 4'(FIFO_DEPTH);
  assign push = cap && cap_keep && !kill;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = accept && length != '0 ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt = kill ? ST_IDLE : iss && icnt == len_r ? ST_DRAIN : ST_ISSUE;
      ST_DRAIN: state_nxt = kill || (hs && m_last) ? ST_IDLE : ST_DRAIN;
      default:  state_nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    busy = state != ST_IDLE;
    done = zdone || kill || (state == ST_DRAIN && hs && m_last);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      raddr <= '0;
      len_r <= '0;
      icnt <= '0;
      iss <= 1'b0;
      cap <= 1'b0;
      cap_keep <= 1'b0;
      iss_last <= 1'b0;
      cap_last <= 1'b0;
      zdone <= 1'b0;
    end else begin
      zdone <= accept && length == '0;
      len_r <= accept ? length : len_r;
      icnt <= accept ? LEN_WIDTH'(1) : iss_nxt ? icnt + 1'b1 : icnt;
      raddr <= accept ? base_addr : iss ? raddr + 1'b1 : raddr;
      iss <= iss_nxt;
      iss_last <= iss_nxt && (accept ? length == LEN_WIDTH'(1) : icnt + 1'b1 == len_r);
      cap <= iss;
      cap_last <= iss_last;
      // reads still in flight at an abort come back but are dropped
      cap_keep <= iss && !kill;
    end
  stream_fifo4 #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(push),
    .pop(hs),
    .flush(kill),
    .din({cap_last, rdata}),
    .dout(head),
    .valid(m_valid),
    .count(fifo_count)
  );
  assign m_last = head[DATA_WIDTH];
  assign m_data = head[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed self-checking bench for ram_stream_reader
module tb_ram_stream_reader;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [8:0] base_addr = '0, raddr;
  logic [9:0] length = '0;
  logic busy, done, m_valid, m_last;
  logic [7:0] m_data, rdata;
  logic [7:0] mem [512];
  int vecs = 0, errs = 0;
  int n, lat, last_c, stab, dn, dn_last, dn_ab, lastn, occ_max;
  logic [8:0] aq[$];
  logic quiet;

  always #5 clk = ~clk;
  always_ff @(posedge clk) rdata <= mem[raddr];

  ram_stream_reader dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .raddr(raddr), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .rdata(rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: m_ready held high; mode 1: m_ready 1,0,0,1 repeating
  // ab >= 0: abort once ab beats have transferred; st2 > 0: extra start at that cycle
  task automatic run(input logic [8:0] b, input logic [9:0] l, input int mode, input int ab, input int st2);
    logic hv, fin;
    logic [7:0] hd;
    int idx;
    n = 0; lat = -1; last_c = -1; stab = 0; dn = 0; dn_last = 0; dn_ab = 0; lastn = 0; occ_max = 0;
    aq.delete(); hv = 0; hd = '0; fin = 0;
    @(negedge clk); base_addr = b; length = l; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < 300 && !fin; c++) begin
      idx = (c - 1) % 4;
      m_ready = mode == 0 || idx == 0 || idx == 3;
      abort = ab >= 0 && n == ab && m_valid;
      if (abort) m_ready = 1'b0;
      start = c == st2;
      if (start) begin base_addr = 9'h0AA; length = 10'd2; end
      #1;
      if (aq.size() == 0 || aq[$] != raddr) aq.push_back(raddr);
      if (int'(dut.fifo_count) + int'(dut.inflight) > occ_max) occ_max = int'(dut.fifo_count) + int'(dut.inflight);
      if (m_valid && lat < 0) lat = c - 1;
      if (hv && !(m_valid && m_data == hd)) stab++;
      hv = m_valid && !m_ready;
      hd = m_data;
      if (done) dn++;
      if (abort) begin dn_ab = done; fin = 1; end
      if (m_valid && m_ready) begin
        logic [8:0] a;
        a = b + 9'(n);
        check($sformatf("beat%0d_data", n), m_data, mem[a]);
        check($sformatf("beat%0d_last", n), m_last, n == int'(l) - 1);
        if (m_last) begin lastn++; dn_last = done; last_c = c - 1; fin = 1; end
        n++;
      end
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0; m_ready = 1'b1;
    check("complete", fin, 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    mem[16] = 8'hA0; mem[17] = 8'hA1; mem[18] = 8'hA2; mem[19] = 8'hA3;
    #3;
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_raddr", raddr, 0);
    check("rst_valid", m_valid, 0); check("rst_last", m_last, 0); check("rst_data", m_data, 0);
    @(negedge clk); resetn = 1'b1; m_ready = 1'b1;

    run(9'h010, 10'd4, 0, -1, 0);
    check("basic_lat", lat, 2); check("basic_beats", n, 4); check("basic_end", last_c, 5);
    check("basic_done_at_last", dn_last, 1); check("basic_done_cnt", dn, 1); check("basic_lastn", lastn, 1);
    #1 check("basic_busy_after", busy, 0);

    run(9'h080, 10'd8, 1, -1, 0);
    check("bp_beats", n, 8); check("bp_stable", stab, 0); check("bp_occ_le4", occ_max <= 4, 1);
    check("bp_lastn", lastn, 1); check("bp_done_cnt", dn, 1);

    run(9'h1FE, 10'd4, 0, -1, 0);
    check("wrap_beats", n, 4); check("wrap_a0", aq[0], 9'h1FE); check("wrap_a1", aq[1], 9'h1FF);
    check("wrap_a2", aq[2], 9'h000); check("wrap_a3", aq[3], 9'h001);

    @(negedge clk); base_addr = 9'h050; length = 10'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1 check("zero_done", done, 1); check("zero_busy", busy, 0); check("zero_valid", m_valid, 0);
    @(negedge clk); #1 check("zero_done_off", done, 0);
    quiet = 1'b1;
    repeat (3) begin @(negedge clk); #1 if (m_valid || busy) quiet = 1'b0; end
    check("zero_quiet", quiet, 1);

    run(9'h020, 10'd5, 0, -1, 2);
    check("restart_beats", n, 5); check("restart_done_cnt", dn, 1);

    run(9'h040, 10'd16, 0, 3, 0);
    check("abort_beats", n, 3); check("abort_done", dn_ab, 1); check("abort_lastn", lastn, 0);
    #1 check("abort_valid_next", m_valid, 0); check("abort_last_next", m_last, 0);
    check("abort_busy_next", busy, 0); check("abort_done_once", done, 0);
    quiet = 1'b1;
    repeat (3) begin @(negedge clk); #1 if (m_valid || done) quiet = 1'b0; end
    check("abort_discard", quiet, 1);
    run(9'h100, 10'd2, 0, -1, 0);
    check("post_abort_beats", n, 2); check("post_abort_lastn", lastn, 1);

    @(negedge clk); base_addr = 9'h030; length = 10'd16; start = 1'b1; m_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("pre_rst_busy", busy, 1); check("pre_rst_valid", m_valid, 1);
    @(posedge clk); #2 resetn = 1'b0;
    #1 check("arst_busy", busy, 0); check("arst_valid", m_valid, 0); check("arst_raddr", raddr, 0);
    check("arst_data", m_data, 0); check("arst_last", m_last, 0); check("arst_done", done, 0);
    @(negedge clk); resetn = 1'b1; m_ready = 1'b1;
    run(9'h010, 10'd3, 0, -1, 0);
    check("rst_run_lat", lat, 2); check("rst_run_beats", n, 3); check("rst_run_done", dn_last, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
